// File: rtl/game_ctrl.sv
// Game sequencer for the flappy-bird datapath: tracks game state, drives restart and
// jump pulses, and keeps the current and best score by watching tubes cross the bird.
module game_ctrl #(
   parameter int BIRD_X       = 200,
   parameter int TUBE_WIDTH   = 120,
   parameter int SCREEN_W     = 1024,
   parameter int DEATH_FRAMES = 90,
   parameter int SCORE_MAX    = 999
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mouse_left_i,
   input  logic        vblnk_i,
   input  logic        collision_i,
   input  logic [10:0] tube_x0_i,
   input  logic [10:0] tube_x1_i,
   input  logic [10:0] tube_x2_i,
   output logic        game_rst_o,
   output logic        mouse_left_game_o,
   output logic        freeze_o,
   output logic [1:0]  state_o,
   output logic [9:0]  score_o,
   output logic [9:0]  best_o
);

   // state    | meaning
   // S_IDLE   | waiting for a click to start, score held at 0
   // S_PLAYING| clicks become jumps, tube passes are scored each frame
   // S_DYING  | physics frozen, counting DEATH_FRAMES frame ticks
   // S_OVER   | frozen, waiting for a fresh click to return to idle
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAYING = 2'd1,
      S_DYING   = 2'd2,
      S_OVER    = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(DEATH_FRAMES);

   state_t              state_q, state_d;
   logic                game_rst_q, game_rst_d;
   logic                jump_q, jump_d;
   logic                freeze_q, freeze_d;
   logic [9:0]          score_q, score_d;
   logic [9:0]          best_q, best_d;
   logic                mouse_d_q, vblnk_d_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                prev_valid_q, prev_valid_d;
   logic [2:0][10:0]    prev_x_q, prev_x_d;
   logic [2:0][11:0]    prev_edge_q, prev_edge_d;

   logic                click, tick;
   logic [2:0][10:0]    tube_x;
   logic [2:0][11:0]    edge_x;
   logic [2:0]          pass;
   logic [1:0]          n_pass;
   logic [10:0]         score_sum;
   logic [9:0]          score_sat;

   assign click  = mouse_left_i & ~mouse_d_q;
   assign tick   = vblnk_i & ~vblnk_d_q;
   assign tube_x = {tube_x2_i, tube_x1_i, tube_x0_i};

   // A pass needs both samples on-screen, so a tube wrapping back to the right never counts.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         edge_x[i] = {1'b0, tube_x[i]} + 12'(TUBE_WIDTH);
         pass[i]   = prev_valid_q
                     && (tube_x[i] < 11'(SCREEN_W))
                     && (prev_x_q[i] < 11'(SCREEN_W))
                     && (prev_edge_q[i] >= 12'(BIRD_X))
                     && (edge_x[i] < 12'(BIRD_X));
      end
      n_pass    = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
      score_sum = {1'b0, score_q} + {9'b0, n_pass};
      score_sat = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
   end

   always_comb begin
      state_d      = state_q;
      game_rst_d   = 1'b0;
      jump_d       = 1'b0;
      score_d      = score_q;
      best_d       = best_q;
      cnt_d        = cnt_q;
      prev_valid_d = prev_valid_q;
      prev_x_d     = prev_x_q;
      prev_edge_d  = prev_edge_q;
      case (state_q)
         S_IDLE: begin
            score_d      = '0;
            prev_valid_d = 1'b0;
            if (click) begin
               state_d    = S_PLAYING;
               game_rst_d = 1'b1;
            end
         end
         S_PLAYING: begin
            jump_d = click;
            if (collision_i) begin
               state_d = S_DYING;
               cnt_d   = '0;
            end else if (tick) begin
               score_d = score_sat;
            end
            if (tick) begin
               prev_valid_d = 1'b1;
               prev_x_d     = tube_x;
               prev_edge_d  = edge_x;
            end
         end
         S_DYING: begin
            if (tick) begin
               if (cnt_q == CNT_W'(DEATH_FRAMES - 1)) begin
                  state_d = S_OVER;
                  if (score_q > best_q) best_d = score_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_OVER: begin
            if (click) begin
               state_d = S_IDLE;
               score_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      freeze_d = (state_d == S_DYING) || (state_d == S_OVER);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         game_rst_q   <= 1'b0;
         jump_q       <= 1'b0;
         freeze_q     <= 1'b0;
         score_q      <= '0;
         best_q       <= '0;
         mouse_d_q    <= 1'b0;
         vblnk_d_q    <= 1'b0;
         cnt_q        <= '0;
         prev_valid_q <= 1'b0;
         prev_x_q     <= '0;
         prev_edge_q  <= '0;
      end else begin
         state_q      <= state_d;
         game_rst_q   <= game_rst_d;
         jump_q       <= jump_d;
         freeze_q     <= freeze_d;
         score_q      <= score_d;
         best_q       <= best_d;
         mouse_d_q    <= mouse_left_i;
         vblnk_d_q    <= vblnk_i;
         cnt_q        <= cnt_d;
         prev_valid_q <= prev_valid_d;
         prev_x_q     <= prev_x_d;
         prev_edge_q  <= prev_edge_d;
      end
   end

   assign game_rst_o        = game_rst_q;
   assign mouse_left_game_o = jump_q;
   assign freeze_o          = freeze_q;
   assign state_o           = state_q;
   assign score_o           = score_q;
   assign best_o            = best_q;

endmodule
